lc3_datapath_param: RTL
=======================

Name: lc3_datapath_param

Overview:
- Parametrised LC-3 datapath: PC, IR, MAR, MDR, 8-entry register file, ALU, address adder, NZP condition codes, BEN, and a single gated internal bus.
- Driven cycle-by-cycle by the ISDU control FSM.
- Word width and memory address width are generalised.
- Adds bus-contention detection with a sticky error flag.

Parameters:
DATA_W, 16, datapath word width; must be >= 16; LC-3 instruction fields sit at fixed bits 15:0 of IR
ADDR_W, 20, memory address width; must be >= DATA_W; MAR is zero-extended to this
RESET_PC, 0, PC value after reset, truncated to DATA_W

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben  in  1 each  register load enables
GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drive enables, intended one-hot
pcmux_sel  in  2  0: PC+1, 1: bus, 2: address adder, 3: hold PC
drmux_sel  in  1  0: IR[11:9], 1: R7
sr1mux_sel  in  1  0: IR[8:6], 1: IR[11:9]
sr2mux_sel  in  1  0: R[IR[2:0]], 1: sext(IR[4:0])
addr1mux_sel  in  1  0: PC, 1: SR1 value
addr2mux_sel  in  2  0: zero, 1: sext(IR[5:0]), 2: sext(IR[8:0]), 3: sext(IR[10:0])
aluk  in  2  0: ADD, 1: AND, 2: NOT A, 3: PASS A
mio_en  in  1  MDR source: 1 = mem_rdata, 0 = bus
mem_rdata  in  DATA_W  memory read data
mem_address  out  ADDR_W  zero-extended MAR
mem_wdata  out  DATA_W  MDR contents
IR  out  DATA_W  instruction register
PC  out  DATA_W  program counter
BEN  out  1  branch enable register
nzp  out  3  condition codes {N,Z,P}
bus_conflict  out  1  combinational; more than one Gate* asserted this cycle
bus_err_sticky  out  1  registered; set on any cycle with bus_conflict, cleared only by reset

Behaviour:
- Reset (synchronous, has priority over every load):
  - PC = RESET_PC; IR, MAR, MDR, R0-R7 = 0; nzp = 3'b010; BEN = 0; bus_err_sticky = 0.
  - Reset asserted mid-instruction discards all pending loads that cycle.
- Bus:
  - Exactly one gate asserted: bus = that source. MARMUX source = address adder output.
  - No gate asserted: bus = 0.
  - More than one gate asserted: bus = 0, bus_conflict = 1, and any register loading from the bus captures 0.
- Address adder = ADDR1 + ADDR2, mod 2^DATA_W. Sign extension is to DATA_W.
- ALU operands:
  - A = SR1 register value.
  - B = sr2mux output.
  - ADD wraps mod 2^DATA_W; no carry or overflow output.
- PC:
  - Loads pcmux output when ld_pc=1.
  - PC+1 wraps: all-ones -> 0.
  - pcmux_sel=3 with ld_pc=1 leaves PC unchanged.
- IR and MAR load from the bus. MDR loads the mio_en-selected source. All load one cycle after the control signal is sampled, on the same edge.
- Register file:
  - Write R[DR] = bus on edge when ld_reg=1.
  - Reads are combinational and return the pre-edge value; no write-through when reading the register being written.
  - R7 selectable via drmux_sel=1 (JSR/TRAP linkage).
- Condition codes: on ld_cc, from the current bus value:
  - N = bus[DATA_W-1]
  - Z = (bus == 0)
  - P = !N && !Z
  - Exactly one bit is always set.
- BEN: on ld_ben, BEN = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), using nzp and IR values before the edge.
- Simultaneous ld_cc and ld_ben: BEN uses the old nzp.
- Simultaneous ld_ir and ld_ben: BEN uses the old IR.
- Multiple loads in one cycle from the same bus value are legal and all capture that value.
- Outputs reflect registered state; only bus_conflict is combinational.

Test Plan:
1. Fetch with RESET_PC=16'h3000 and reset for 2 cycles. Then: GatePC+ld_mar; then pcmux_sel=0+ld_pc with mio_en=1+ld_mdr and mem_rdata=16'h1261; then GateMDR+ld_ir -> mem_address=20'h03000, PC=16'h3001, IR=16'h1261.
2. ADD immediate: R1=5, IR=16'h1261 (R1 <- R1 + sext(1)), sr2mux_sel=1, aluk=0, GateALU+ld_reg+ld_cc. Then repeat with IR=16'h127F (imm -1) from R1=0 -> R1=16'hFFFF, nzp=100.
3. Branch: nzp=010, IR=16'h0405 (BRz), ld_ben -> BEN=1. Then pcmux_sel=2, addr1mux_sel=0, addr2mux_sel=2, ld_pc with PC=16'h3001 -> PC=16'h3006. With IR=16'h0805 (BRn) -> BEN=0.
4. PC wrap: PC=16'hFFFF, pcmux_sel=0, ld_pc -> PC=16'h0000.
5. Bus conflict: GatePC and GateALU both high with ld_mar -> bus_conflict=1, MAR=0, bus_err_sticky=1 on the next cycle and still 1 after 10 idle cycles. Then reset -> bus_err_sticky=0.
6. Reset mid-operation: ld_reg=1 with bus=16'h1234 and reset=1 in the same cycle -> all registers read 0, nzp=010, PC=RESET_PC.

Source files
------------

// File: rtl/lc3_datapath_param_if.sv
`default_nettype none
// ============================================================================
// Module : lc3_datapath_param_if
// Brief  : Control/status bundle between the ISDU and the LC-3 datapath.
// Rev    : 1.0  initial release
// ============================================================================
interface lc3_datapath_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
);
  logic              ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben;
  logic              GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]        pcmux_sel;
  logic              drmux_sel, sr1mux_sel, sr2mux_sel, addr1mux_sel;
  logic [1:0]        addr2mux_sel;
  logic [1:0]        aluk;
  logic              mio_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] PC;
  logic              BEN;
  logic [2:0]        nzp;
  logic              bus_conflict;
  logic              bus_err_sticky;

  modport master (
    output ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output pcmux_sel, drmux_sel, sr1mux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel,
    output aluk, mio_en, mem_rdata,
    input  mem_address, mem_wdata, IR, PC, BEN, nzp, bus_conflict, bus_err_sticky
  );

  modport slave (
    input  ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc, ld_ben,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  pcmux_sel, drmux_sel, sr1mux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel,
    input  aluk, mio_en, mem_rdata,
    output mem_address, mem_wdata, IR, PC, BEN, nzp, bus_conflict, bus_err_sticky
  );
endinterface
`default_nettype wire

// File: rtl/lc3_datapath_param.sv
`default_nettype none
// ============================================================================
// Module : lc3_datapath_param
// Brief  : Parametrised LC-3 datapath with single gated bus and contention flag.
// Rev    : 1.0  initial release
// ============================================================================
module lc3_datapath_param #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 20,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  lc3_datapath_param_if.slave  io_dp
);
  localparam logic [DATA_W-1:0] c_reset_pc = DATA_W'(RESET_PC);

  logic [DATA_W-1:0] r_pc, r_ir, r_mar, r_mdr;
  logic [DATA_W-1:0] r_rf [8];
  logic [2:0]        r_nzp;
  logic              r_ben, r_err;

  logic [3:0]        w_gates;
  logic              w_conflict;
  logic [2:0]        w_sr1_idx, w_dr;
  logic [DATA_W-1:0] w_sr1, w_sr2, w_alu, w_addr1, w_addr2, w_adder;
  logic [DATA_W-1:0] w_bus, w_pcmux, w_mdr_in;
  logic [DATA_W-1:0] w_imm5, w_off6, w_off9, w_off11;

  assign w_imm5  = {{(DATA_W-5){r_ir[4]}},   r_ir[4:0]};
  assign w_off6  = {{(DATA_W-6){r_ir[5]}},   r_ir[5:0]};
  assign w_off9  = {{(DATA_W-9){r_ir[8]}},   r_ir[8:0]};
  assign w_off11 = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};

  assign w_sr1_idx = io_dp.sr1mux_sel ? r_ir[11:9] : r_ir[8:6];
  assign w_dr      = io_dp.drmux_sel  ? 3'd7       : r_ir[11:9];
  assign w_sr1     = r_rf[w_sr1_idx];
  assign w_sr2     = io_dp.sr2mux_sel ? w_imm5 : r_rf[r_ir[2:0]];

  always_comb begin
    w_alu = w_sr1;
    case (io_dp.aluk)
      2'd0:    w_alu = w_sr1 + w_sr2;
      2'd1:    w_alu = w_sr1 & w_sr2;
      2'd2:    w_alu = ~w_sr1;
      default: w_alu = w_sr1;
    endcase
  end

  assign w_addr1 = io_dp.addr1mux_sel ? w_sr1 : r_pc;

  always_comb begin
    w_addr2 = '0;
    case (io_dp.addr2mux_sel)
      2'd1:    w_addr2 = w_off6;
      2'd2:    w_addr2 = w_off9;
      2'd3:    w_addr2 = w_off11;
      default: w_addr2 = '0;
    endcase
  end

  assign w_adder = w_addr1 + w_addr2;

  // Anything other than a single active gate leaves the bus at zero.
  assign w_gates    = {io_dp.GatePC, io_dp.GateMDR, io_dp.GateALU, io_dp.GateMARMUX};
  assign w_conflict = (w_gates & (w_gates - 4'd1)) != 4'd0;

  always_comb begin
    w_bus = '0;
    case (w_gates)
      4'b1000: w_bus = r_pc;
      4'b0100: w_bus = r_mdr;
      4'b0010: w_bus = w_alu;
      4'b0001: w_bus = w_adder;
      default: w_bus = '0;
    endcase
  end

  always_comb begin
    w_pcmux = r_pc;
    case (io_dp.pcmux_sel)
      2'd0:    w_pcmux = r_pc + 1'b1;
      2'd1:    w_pcmux = w_bus;
      2'd2:    w_pcmux = w_adder;
      default: w_pcmux = r_pc;
    endcase
  end

  assign w_mdr_in = io_dp.mio_en ? io_dp.mem_rdata : w_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= c_reset_pc;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_nzp <= 3'b010;
      r_ben <= 1'b0;
      r_err <= 1'b0;
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else begin
      if (io_dp.ld_pc)  r_pc  <= w_pcmux;
      if (io_dp.ld_ir)  r_ir  <= w_bus;
      if (io_dp.ld_mar) r_mar <= w_bus;
      if (io_dp.ld_mdr) r_mdr <= w_mdr_in;
      if (io_dp.ld_reg) r_rf[w_dr] <= w_bus;
      if (io_dp.ld_cc)
        r_nzp <= {w_bus[DATA_W-1], w_bus == '0, !w_bus[DATA_W-1] && (w_bus != '0)};
      // Old IR and old nzp are sampled, so same-cycle ld_ir/ld_cc do not leak in.
      if (io_dp.ld_ben) r_ben <= |(r_ir[11:9] & r_nzp);
      if (w_conflict)   r_err <= 1'b1;
    end
  end

  assign io_dp.mem_address    = ADDR_W'(r_mar);
  assign io_dp.mem_wdata      = r_mdr;
  assign io_dp.IR             = r_ir;
  assign io_dp.PC             = r_pc;
  assign io_dp.BEN            = r_ben;
  assign io_dp.nzp            = r_nzp;
  assign io_dp.bus_conflict   = w_conflict;
  assign io_dp.bus_err_sticky = r_err;
endmodule
`default_nettype wire
